instr_sequencer: RTL and testbench

Multi-cycle sequencer FSM for the RV32 datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the strobes for the IR, ALU-out register, MDR, PC and register file. It consumes the decoder's class flags and handshakes with instruction and data memory using req/ready. It also enforces memory-wait timeouts and raises a sticky trap on an illegal opcode or a bus timeout.

---
 rtl/riscv_ctrl_pkg.sv | 21 ++
 rtl/instr_sequencer_if.sv | 10 +
 rtl/instr_sequencer_mem_wait_timer.sv | 19 +
 rtl/instr_sequencer.sv | 104 ++++++++++
 tb/tb_instr_sequencer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: sequencer states, trap causes, pc_sel codes and RV32 opcodes
package riscv_ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} seq_state_t;
    typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_IMEM_TIMEOUT, CAUSE_DMEM_TIMEOUT} trap_cause_t;
    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_TARGET = 2'b01;
    localparam logic [1:0] PC_SEL_JALR   = 2'b10;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    function automatic logic opcode_legal(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                           OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
    endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction/data memory req-ready handshake
interface instr_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;
    modport master(output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
    modport slave(input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/instr_sequencer_mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready cycles, flags the last tolerated one
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int W = $clog2(MEM_TIMEOUT);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : waiting ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign expired = waiting && (cnt_q == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle RV32 control FSM with memory-wait timeout and sticky trap
module instr_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                is_mem_read,
    input  logic                is_mem_write,
    input  logic                is_reg_write,
    input  logic                is_branch,
    input  logic                is_jal,
    input  logic                is_jalr,
    input  logic                branch_taken,
    instr_sequencer_if.master   bus,
    output logic                ir_load,
    output logic                alu_out_load,
    output logic                mdr_load,
    output logic                rf_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] retire_count,
    output logic [2:0]          state
);
    seq_state_t          state_q, state_d;
    trap_cause_t         trap_cause_q, trap_cause_d;
    logic [RETIRE_W-1:0] retire_count_q, retire_count_d;
    logic                in_wait, ready, waiting, expired, run;
    assign run     = !rst;
    assign in_wait = (state_q == FETCH) || (state_q == MEM);
    assign ready   = (state_q == FETCH) ? bus.imem_ready : bus.dmem_ready;
    assign waiting = in_wait && !ready;
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_wait || ready),
        .waiting (waiting),
        .expired (expired)
    );
    always_comb begin
        state_d        = state_q;
        trap_cause_d   = trap_cause_q;
        retire_count_d = retire_count_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ready) state_d = DECODE;
                else if (expired) begin
                    state_d      = TRAP;
                    trap_cause_d = CAUSE_IMEM_TIMEOUT;
                end
            end
            DECODE: begin
                state_d      = opcode_legal(opcode) ? EXECUTE : TRAP;
                trap_cause_d = opcode_legal(opcode) ? trap_cause_q : CAUSE_ILLEGAL;
            end
            EXECUTE: state_d = (is_mem_read || is_mem_write) ? MEM : WRITEBACK;
            MEM: begin
                if (bus.dmem_ready) state_d = WRITEBACK;
                else if (expired) begin
                    state_d      = TRAP;
                    trap_cause_d = CAUSE_DMEM_TIMEOUT;
                end
            end
            WRITEBACK: begin
                state_d        = FETCH;
                retire_count_d = retire_count_q + RETIRE_W'(1);
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FETCH;
            trap_cause_q   <= CAUSE_NONE;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            trap_cause_q   <= trap_cause_d;
            retire_count_q <= retire_count_d;
        end
    end
    // every strobe is masked while rst is high so a reset mid-instruction never commits it
    assign bus.imem_req  = run && (state_q == FETCH);
    assign bus.dmem_req  = run && (state_q == MEM);
    assign bus.dmem_we   = run && (state_q == MEM) && is_mem_write;
    assign ir_load       = run && (state_q == FETCH) && bus.imem_ready;
    assign alu_out_load  = run && (state_q == EXECUTE);
    assign mdr_load      = run && (state_q == MEM) && bus.dmem_ready && is_mem_read;
    assign rf_we         = run && (state_q == WRITEBACK) && is_reg_write;
    assign pc_we         = run && (state_q == WRITEBACK);
    assign pc_sel        = !(run && (state_q == WRITEBACK)) ? PC_SEL_SEQ :
                           is_jalr ? PC_SEL_JALR :
                           (is_jal || (is_branch && branch_taken)) ? PC_SEL_TARGET : PC_SEL_SEQ;
    assign trap          = run && (state_q == TRAP);
    assign trap_cause    = run ? trap_cause_q : CAUSE_NONE;
    assign retire_count  = retire_count_q;
    assign state         = state_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized instruction stream against a per-instruction cycle script
module tb_instr_sequencer;
    import riscv_ctrl_pkg::*;
    localparam int TO = 4;
    localparam int RW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] opcode = '0;
    logic is_mem_read = 0, is_mem_write = 0, is_reg_write = 0;
    logic is_branch = 0, is_jal = 0, is_jalr = 0, branch_taken = 0;
    logic ir_load, alu_out_load, mdr_load, rf_we, pc_we, trap;
    logic [1:0] pc_sel, trap_cause;
    logic [RW-1:0] retire_count;
    logic [2:0] state;
    logic [15:0] obs;
    int checks = 0, failures = 0, retired = 0;
    instr_sequencer_if bus();
    instr_sequencer #(.MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .is_mem_read(is_mem_read), .is_mem_write(is_mem_write), .is_reg_write(is_reg_write),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .branch_taken(branch_taken),
        .bus(bus), .ir_load(ir_load), .alu_out_load(alu_out_load), .mdr_load(mdr_load),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause),
        .retire_count(retire_count), .state(state)
    );
    always #5 clk = ~clk;
    assign obs = {state, trap_cause, trap, pc_sel, pc_we, rf_we, mdr_load, alu_out_load,
                  ir_load, bus.dmem_we, bus.dmem_req, bus.imem_req};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] ev(input seq_state_t s, input logic [1:0] cause, input logic tr,
            input logic [1:0] psel, input logic pcw, input logic rfw, input logic mdr, input logic alu,
            input logic irl, input logic dwe, input logic dreq, input logic ireq);
        return {s, cause, tr, psel, pcw, rfw, mdr, alu, irl, dwe, dreq, ireq};
    endfunction
    task automatic step(input string tag, input logic [15:0] exp);
        @(negedge clk);
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask
    task automatic check_retire(input string tag);
        check(tag, 32'(retire_count), 32'(retired % (1 << RW)));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) begin
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            step("reset", ev(FETCH, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        rst = 1'b0;
        retired = 0;
        check_retire("reset_retire");
    endtask
    task automatic trap_hold(input logic [1:0] cause);
        repeat (3) begin
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            step("trap", ev(TRAP, cause, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        do_reset();
    endtask
    // kinds: 0 add, 1 addi, 2 lw, 3 sw, 4 beq, 5 jal, 6 jalr, 7 lui, 8 auipc, 9 illegal fence
    task automatic run_instr(input int k, input logic tk, input int iw, input int dw);
        logic rd, wr, rw;
        logic [1:0] psel;
        int c;
        case (k)
            0: opcode = 7'b0110011; 1: opcode = 7'b0010011; 2: opcode = 7'b0000011;
            3: opcode = 7'b0100011; 4: opcode = 7'b1100011; 5: opcode = 7'b1101111;
            6: opcode = 7'b1100111; 7: opcode = 7'b0110111; 8: opcode = 7'b0010111;
            default: opcode = 7'b0001111;
        endcase
        rd = (k == 2);
        wr = (k == 3);
        rw = k inside {0, 1, 2, 5, 6, 7, 8};
        psel = (k == 6) ? 2'b10 : ((k == 5) || (k == 4 && tk)) ? 2'b01 : 2'b00;
        is_mem_read = rd; is_mem_write = wr; is_reg_write = rw;
        is_branch = (k == 4); is_jal = (k == 5); is_jalr = (k == 6); branch_taken = tk;
        c = 0;
        while (1) begin
            bus.imem_ready = (c == iw);
            bus.dmem_ready = 1'($urandom);
            step("fetch", ev(FETCH, 2'b00, 0, 2'b00, 0, 0, 0, 0, c == iw, 0, 0, 1));
            if (c == iw) break;
            if (c == TO - 1) begin
                trap_hold(2'b10);
                return;
            end
            c++;
        end
        bus.imem_ready = 1'($urandom);
        bus.dmem_ready = 1'($urandom);
        step("decode", ev(DECODE, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        if (k == 9) begin
            trap_hold(2'b01);
            return;
        end
        step("execute", ev(EXECUTE, 2'b00, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
        if (rd || wr) begin
            c = 0;
            while (1) begin
                bus.dmem_ready = (c == dw);
                bus.imem_ready = 1'($urandom);
                step("mem", ev(MEM, 2'b00, 0, 2'b00, 0, 0, (c == dw) && rd, 0, 0, wr, 1, 0));
                if (c == dw) break;
                if (c == TO - 1) begin
                    trap_hold(2'b11);
                    return;
                end
                c++;
            end
        end
        bus.imem_ready = 1'($urandom);
        bus.dmem_ready = 1'($urandom);
        step("writeback", ev(WRITEBACK, 2'b00, 0, psel, 1, rw, 0, 0, 0, 0, 0, 0));
        retired++;
        check_retire("retire");
    endtask
    initial begin
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        do_reset();
        run_instr(1, 0, 0, 0);
        run_instr(2, 0, 0, 3);
        run_instr(3, 0, 1, 0);
        run_instr(4, 1, 0, 0);
        run_instr(4, 0, 0, 0);
        run_instr(6, 0, 0, 0);
        run_instr(5, 0, 2, 0);
        run_instr(1, 0, 3, 0);
        run_instr(2, 0, 0, 3);
        run_instr(1, 0, 4, 0);
        run_instr(2, 0, 0, 4);
        run_instr(9, 0, 0, 0);
        repeat (20) run_instr(1, 0, 0, 0);
        opcode = 7'b0000011;
        is_mem_read = 1; is_mem_write = 0; is_reg_write = 1;
        is_branch = 0; is_jal = 0; is_jalr = 0;
        run_instr(1, 0, 0, 0);
        opcode = 7'b0000011;
        is_mem_read = 1; is_mem_write = 0; is_reg_write = 1; is_branch = 0; is_jal = 0; is_jalr = 0;
        bus.imem_ready = 1'b1;
        step("rst_fetch", ev(FETCH, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1));
        step("rst_decode", ev(DECODE, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step("rst_execute", ev(EXECUTE, 2'b00, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
        bus.dmem_ready = 1'b0;
        step("rst_mem", ev(MEM, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
        rst = 1'b1;
        bus.dmem_ready = 1'b1;
        step("rst_in_mem", ev(MEM, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        retired = 0;
        bus.imem_ready = 1'b0;
        step("rst_after", ev(FETCH, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
        check_retire("rst_after_retire");
        do_reset();
        repeat (80) begin
            automatic int iw = ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, TO - 1));
            automatic int dw = ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, TO - 1));
            automatic int k = ($urandom_range(0, 24) == 0) ? 9 : int'($urandom_range(0, 8));
            run_instr(k, 1'($urandom), iw, dw);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
